// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: the request/grant bundle shared by the processing cores and the bus arbiter.
//   req         per-core bus request (level)
//   done        per-core release pulse
//   grant       one-hot grant, all-zero when the bus is free
//   bus_sel     index of the owning core (bus/register mux select)
//   bus_busy    high while any grant is asserted
//   reg_load    one-cycle shared-register load enable at grant start
//   timeout_err one-cycle pulse on a forced release
//   timeout_id  core that was last forced off the bus
// Modports: slave = arbiter side, master = core side.
`timescale 1ns/1ps
interface bus_arbiter_rr_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned SEL_W = 2
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] bus_sel;
    logic             bus_busy;
    logic             reg_load;
    logic             timeout_err;
    logic [SEL_W-1:0] timeout_id;

    modport slave (
        input  req, done,
        output grant, bus_sel, bus_busy, reg_load, timeout_err, timeout_id
    );

    modport master (
        output req, done,
        input  grant, bus_sel, bus_busy, reg_load, timeout_err, timeout_id
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin owner selection for the shared 16-bit data bus and its
// load-enabled registers. Grants one core at a time, bounds ownership to MAX_HOLD cycles
// and inserts a one-cycle turnaround between owners.
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    bus_arbiter_rr_if.slave (req/done in; grant, bus_sel, bus_busy, reg_load,
//          timeout_err, timeout_id out, all registered)
`timescale 1ns/1ps
module bus_arbiter_rr #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    bus_arbiter_rr_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
    logic [N_REQ-1:0] r_grant, w_grant_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_load, w_load_nxt;
    logic             r_terr, w_terr_nxt;
    logic [SEL_W-1:0] r_tid, w_tid_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;

    logic             w_pick_valid;
    logic [SEL_W-1:0] w_pick_idx;
    logic [SEL_W-1:0] w_cand;
    logic [SEL_W-1:0] w_sel_succ;

    // First requester found scanning ptr, ptr+1, ... modulo N_REQ.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_cand       = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            w_cand = SEL_W'((int'(r_ptr) + i) % int'(N_REQ));
            if (!w_pick_valid && bus.req[w_cand]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    // Pointer value after the current owner releases: the core after it, wrapping.
    assign w_sel_succ = (r_sel == SEL_W'(N_REQ - 1)) ? '0 : r_sel + SEL_W'(1);

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_busy_nxt  = r_busy;
        w_load_nxt  = 1'b0;
        w_terr_nxt  = 1'b0;
        w_tid_nxt   = r_tid;
        w_hold_nxt  = r_hold;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = N_REQ'(1) << w_pick_idx;
                    w_sel_nxt   = w_pick_idx;
                    w_busy_nxt  = 1'b1;
                    w_load_nxt  = 1'b1;
                    w_hold_nxt  = HOLD_W'(1);
                end
            end
            ST_BUSY: begin
                // Only the owner's done/req matter; a done in the limit cycle beats the timeout.
                if (bus.done[r_sel] || !bus.req[r_sel]) begin
                    w_state_nxt = ST_TURN;
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = w_sel_succ;
                end else if (r_hold == HOLD_W'(MAX_HOLD)) begin
                    w_state_nxt = ST_TURN;
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = w_sel_succ;
                    w_terr_nxt  = 1'b1;
                    w_tid_nxt   = r_sel;
                end else begin
                    w_hold_nxt  = r_hold + HOLD_W'(1);
                end
            end
            ST_TURN: begin
                // Turnaround cycle: bus idle, bus_sel keeps the previous owner.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_load  <= 1'b0;
            r_terr  <= 1'b0;
            r_tid   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_busy  <= w_busy_nxt;
            r_load  <= w_load_nxt;
            r_terr  <= w_terr_nxt;
            r_tid   <= w_tid_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.bus_sel     = r_sel;
    assign bus.bus_busy    = r_busy;
    assign bus.reg_load    = r_load;
    assign bus.timeout_err = r_terr;
    assign bus.timeout_id  = r_tid;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: self-checking bench for bus_arbiter_rr (vector table, directed
// multi-cycle sequences and random traffic against a behavioural ownership model).
`timescale 1ns/1ps
module tb_bus_arbiter_rr;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    bus_arbiter_rr_if #(.N_REQ(4), .SEL_W(2)) intf ();

    bus_arbiter_rr #(.N_REQ(4), .SEL_W(2), .MAX_HOLD(16), .HOLD_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: who owns the bus, how long, and who is next in line.
    int owner;     // -1 when nobody owns the bus
    int age;       // cycles the owner has held the bus
    int next_core; // where the fairness scan starts
    bit cooling;   // one quiet cycle after every release
    int m_sel;
    bit m_load;
    bit m_err;
    int m_tid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_release();
        next_core = (owner + 1) % N;
        owner     = -1;
        cooling   = 1'b1;
    endtask

    task automatic model_step();
        bit found;
        m_load = 1'b0;
        m_err  = 1'b0;
        if (reset) begin
            owner = -1; age = 0; next_core = 0; cooling = 1'b0; m_sel = 0; m_tid = 0;
        end else if (owner >= 0) begin
            if ((((intf.done >> owner) & 4'b0001) != 0) || (((intf.req >> owner) & 4'b0001) == 0)) begin
                model_release();
            end else if (age == MAX_HOLD) begin
                m_err = 1'b1;
                m_tid = owner;
                model_release();
            end else begin
                age++;
            end
        end else if (cooling) begin
            cooling = 1'b0;
        end else begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (next_core + k) % N;
                if (!found && (((intf.req >> c) & 4'b0001) != 0)) begin
                    found  = 1'b1;
                    owner  = c;
                    m_sel  = c;
                    age    = 1;
                    m_load = 1'b1;
                end
            end
        end
    endtask

    // One clock: advance the model with the inputs the DUT sees, then compare just after the edge.
    task automatic step();
        logic [3:0] eg;
        @(posedge clk);
        model_step();
        #1;
        eg = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
        chk("m_grant", 32'(intf.grant), 32'(eg));
        chk("m_sel", 32'(intf.bus_sel), 32'(m_sel));
        chk("m_busy", 32'(intf.bus_busy), 32'(owner >= 0));
        chk("m_load", 32'(intf.reg_load), 32'(m_load));
        chk("m_terr", 32'(intf.timeout_err), 32'(m_err));
        chk("m_tid", 32'(intf.timeout_id), 32'(m_tid));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        intf.req  = 4'b0000;
        intf.done = 4'b0000;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_grant(input int max_cycles);
        int n;
        n = 0;
        while (intf.grant == 4'b0000 && n < max_cycles) begin
            step();
            n++;
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       load;
        logic       err;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        n_chk = 0; n_fail = 0;
        owner = -1; age = 0; next_core = 0; cooling = 1'b0; m_sel = 0; m_load = 1'b0; m_err = 1'b0; m_tid = 0;
        reset = 1'b1; intf.req = 4'b0000; intf.done = 4'b0000;

        // Reset with all requesting, first grant, then core 2 alone for 5 cycles.
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            reset     = vecs[i].rst;
            intf.req  = vecs[i].req;
            intf.done = vecs[i].done;
            step();
            chk("vec_grant", 32'(intf.grant), 32'(vecs[i].grant));
            chk("vec_sel", 32'(intf.bus_sel), 32'(vecs[i].sel));
            chk("vec_busy", 32'(intf.bus_busy), 32'(vecs[i].grant != 4'b0000));
            chk("vec_load", 32'(intf.reg_load), 32'(vecs[i].load));
            chk("vec_terr", 32'(intf.timeout_err), 32'(vecs[i].err));
        end
        intf.done = 4'b0000;

        // Round-robin with everyone requesting, each owner done after 3 cycles.
        do_reset();
        intf.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (n % N);
            wait_grant(4);
            chk("rr_order", 32'(intf.grant), 32'(exp_g));
            step();
            step();
            intf.done = exp_g;
            step();
            intf.done = 4'b0000;
            chk("rr_release", 32'(intf.grant), 32'(0));
        end

        // Timeout: sole requester never finishes.
        do_reset();
        intf.req = 4'b0010;
        wait_grant(4);
        chk("to_grant", 32'(intf.grant), 32'(4'b0010));
        cnt = 1;
        while (intf.grant != 4'b0000 && cnt < 40) begin
            step();
            if (intf.grant != 4'b0000) cnt++;
        end
        chk("to_len", 32'(cnt), 32'(MAX_HOLD));
        chk("to_err", 32'(intf.timeout_err), 32'(1));
        chk("to_id", 32'(intf.timeout_id), 32'(1));
        step();
        chk("to_err_clr", 32'(intf.timeout_err), 32'(0));
        chk("to_gap", 32'(intf.grant), 32'(0));
        step();
        chk("to_regrant", 32'(intf.grant), 32'(4'b0010));
        chk("to_reload", 32'(intf.reg_load), 32'(1));

        // done at the hold limit beats timeout; foreign done ignored.
        do_reset();
        intf.req = 4'b0010;
        wait_grant(4);
        for (int c = 1; c < MAX_HOLD; c++) begin
            intf.done = (c == 4) ? 4'b1000 : 4'b0000;
            step();
            chk("sim_hold", 32'(intf.grant), 32'(4'b0010));
        end
        intf.done = 4'b0010;
        step();
        intf.done = 4'b0000;
        chk("sim_release", 32'(intf.grant), 32'(0));
        chk("sim_noerr", 32'(intf.timeout_err), 32'(0));

        // Reset while core 2 owns the bus.
        do_reset();
        intf.req = 4'b0100;
        wait_grant(4);
        chk("mid_grant", 32'(intf.grant), 32'(4'b0100));
        step();
        reset    = 1'b1;
        intf.req = 4'b0101;
        step();
        chk("mid_drop", 32'(intf.grant), 32'(0));
        chk("mid_busy", 32'(intf.bus_busy), 32'(0));
        reset = 1'b0;
        step();
        chk("mid_next", 32'(intf.grant), 32'(4'b0001));

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) intf.req = 4'($urandom);
            intf.done = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            reset = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
